// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle instruction sequencer with handshaked memory ports
module multicycle_control #(
    parameter int OPCODE_W = 4,
    parameter int FUNCT_W  = 2,
    parameter int ALU_OP_W = 4,
    parameter int TIMEOUT  = 0,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic                fetch_req,
    input  logic                fetch_ack,
    output logic                mem_req,
    output logic                mem_we,
    input  logic                mem_ack,
    input  logic                zero,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                alu_operation,
    output logic [ALU_OP_W-1:0] alu_operation_type,
    output logic                write_register,
    output logic                wb_sel,
    output logic                branch,
    output logic                illegal_op,
    output logic                bus_error,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK
    } state_t;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_LW  = 2'd1;
    localparam logic [1:0] CLS_SW  = 2'd2;
    localparam logic [1:0] CLS_BEQ = 2'd3;

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    state_t              state;
    logic [OPCODE_W-1:0] opcode_q;
    logic [1:0]          funct_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]    count_q;

    logic       op_legal;
    logic [1:0] op_class;
    logic       timeout_hit;
    logic       unused_funct;

    // Only the two low funct bits select the ALU operation
    assign unused_funct = ^funct;

    assign op_legal    = (opcode_q <= OPCODE_W'(3));
    assign op_class    = opcode_q[1:0];
    // Current cycle is the TIMEOUT-th request cycle of this handshake
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);
    assign instr_count = count_q;

    // Output decode from state plus live handshake inputs, all forced low during reset
    always_comb begin
        fetch_req          = 1'b0;
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        ir_write           = 1'b0;
        pc_write           = 1'b0;
        pc_src             = 1'b0;
        alu_operation      = 1'b0;
        alu_operation_type = '0;
        write_register     = 1'b0;
        wb_sel             = 1'b0;
        branch             = 1'b0;
        illegal_op         = 1'b0;
        bus_error          = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    fetch_req = 1'b1;
                    if (fetch_ack) begin
                        ir_write = 1'b1;
                    end else if (timeout_hit) begin
                        bus_error = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!op_legal) begin
                        illegal_op = 1'b1;
                        pc_write   = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    case (op_class)
                        CLS_ALU: begin
                            alu_operation      = 1'b1;
                            alu_operation_type = ALU_OP_W'(funct_q) + ALU_OP_W'(1);
                        end
                        CLS_BEQ: begin
                            alu_operation_type = ALU_OP_W'(2);
                            branch             = 1'b1;
                            pc_write           = 1'b1;
                            pc_src             = zero;
                        end
                        default: alu_operation_type = ALU_OP_W'(1);
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (op_class == CLS_SW);
                    if (mem_ack) begin
                        pc_write = (op_class == CLS_SW);
                    end else if (timeout_hit) begin
                        bus_error = 1'b1;
                        pc_write  = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    write_register = 1'b1;
                    wb_sel         = (op_class == CLS_LW);
                    pc_write       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, instruction capture and handshake wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            opcode_q <= '0;
            funct_q  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_ack) begin
                        opcode_q <= opcode;
                        funct_q  <= funct[1:0];
                        wait_cnt <= '0;
                        state    <= S_DECODE;
                    end else if (timeout_hit) begin
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    wait_cnt <= '0;
                    state    <= op_legal ? S_EXECUTE : S_FETCH;
                end
                S_EXECUTE: begin
                    wait_cnt <= '0;
                    case (op_class)
                        CLS_ALU: state <= S_WRITEBACK;
                        CLS_BEQ: state <= S_FETCH;
                        default: state <= S_MEM;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        state    <= (op_class == CLS_LW) ? S_WRITEBACK : S_FETCH;
                    end else if (timeout_hit) begin
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WRITEBACK: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

    // Retired-instruction counter: PC advances that are neither illegal nor aborted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (pc_write && !illegal_op && !bus_error) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int TMO = 4;

    // expected output word layout
    localparam logic [15:0] FREQ = 16'h8000;
    localparam logic [15:0] MREQ = 16'h4000;
    localparam logic [15:0] MWE  = 16'h2000;
    localparam logic [15:0] IRW  = 16'h1000;
    localparam logic [15:0] PCW  = 16'h0800;
    localparam logic [15:0] PCS  = 16'h0400;
    localparam logic [15:0] ALU  = 16'h0200;
    localparam logic [15:0] WR   = 16'h0010;
    localparam logic [15:0] WB   = 16'h0008;
    localparam logic [15:0] BR   = 16'h0004;
    localparam logic [15:0] ILL  = 16'h0002;
    localparam logic [15:0] BERR = 16'h0001;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       fetch_req, fetch_ack, mem_req, mem_we, mem_ack, zero;
    logic       ir_write, pc_write, pc_src, alu_operation;
    logic [3:0] alu_operation_type;
    logic       write_register, wb_sel, branch, illegal_op, bus_error;
    logic [3:0] instr_count;
    logic [15:0] obs;

    multicycle_control #(
        .OPCODE_W(4), .FUNCT_W(3), .ALU_OP_W(4), .TIMEOUT(TMO), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_operation(alu_operation), .alu_operation_type(alu_operation_type),
        .write_register(write_register), .wb_sel(wb_sel), .branch(branch),
        .illegal_op(illegal_op), .bus_error(bus_error), .instr_count(instr_count)
    );

    assign obs = {fetch_req, mem_req, mem_we, ir_write, pc_write, pc_src, alu_operation,
                  alu_operation_type, write_register, wb_sel, branch, illegal_op, bus_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fa;
        logic        ma;
        logic        z;
        logic [3:0]  op;
        logic [2:0]  fn;
        logic [15:0] e;
    } rec_t;

    rec_t       q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [3:0] exp_count = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] ty(input int t);
        return 16'(t) << 5;
    endfunction

    task automatic push(input logic fa, input logic ma, input logic z, input logic [3:0] op,
                        input logic [2:0] fn, input logic [15:0] e);
        rec_t r;
        r.fa = fa; r.ma = ma; r.z = z; r.op = op; r.fn = fn; r.e = e;
        q.push_back(r);
    endtask

    // Expected cycle trace of one instruction: df fetch wait cycles, dm memory wait
    // cycles, zsel 0/1 forces the zero flag during EXECUTE, 2 randomizes it
    task automatic gen_instr(input logic [3:0] op, input logic [2:0] fn, input int df,
                             input int dm, input int zsel);
        logic        z;
        logic [15:0] we;
        bit          done;
        for (int i = 1; i <= df; i++)
            push(1'b0, r1(), r1(), 4'($urandom), 3'($urandom),
                 FREQ | ((i % TMO == 0) ? BERR : 16'h0));
        push(1'b1, r1(), r1(), op, fn, FREQ | IRW);
        if (op > 4'd3) begin
            push(r1(), r1(), r1(), 4'($urandom), 3'($urandom), ILL | PCW);
        end else begin
            push(r1(), r1(), r1(), 4'($urandom), 3'($urandom), 16'h0);
            z = (zsel == 2) ? r1() : (zsel == 1);
            if (op == 4'd0) begin
                push(r1(), r1(), z, 4'($urandom), 3'($urandom), ALU | ty(int'(fn[1:0]) + 1));
                push(r1(), r1(), r1(), 4'($urandom), 3'($urandom), WR | PCW);
            end else if (op == 4'd3) begin
                push(r1(), r1(), z, 4'($urandom), 3'($urandom), BR | PCW | ty(2) | (z ? PCS : 16'h0));
            end else begin
                push(r1(), r1(), z, 4'($urandom), 3'($urandom), ty(1));
                we = (op == 4'd2) ? MWE : 16'h0;
                done = 0;
                for (int i = 1; !done; i++) begin
                    if (i > dm) begin
                        push(r1(), 1'b1, r1(), 4'($urandom), 3'($urandom),
                             MREQ | we | ((op == 4'd2) ? PCW : 16'h0));
                        if (op == 4'd1)
                            push(r1(), r1(), r1(), 4'($urandom), 3'($urandom), WR | WB | PCW);
                        done = 1;
                    end else if (i == TMO) begin
                        push(r1(), 1'b0, r1(), 4'($urandom), 3'($urandom), MREQ | we | BERR | PCW);
                        done = 1;
                    end else begin
                        push(r1(), 1'b0, r1(), 4'($urandom), 3'($urandom), MREQ | we);
                    end
                end
            end
        end
    endtask

    // Called at a falling edge; applies and checks up to limit queued cycles
    task automatic run_recs(input int limit);
        rec_t r;
        int   n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            r = q.pop_front();
            fetch_ack = r.fa; mem_ack = r.ma; zero = r.z; opcode = r.op; funct = r.fn;
            #1;
            check($sformatf("out_cyc%0d", cyc), 32'(obs), 32'(r.e));
            check($sformatf("cnt_cyc%0d", cyc), 32'(instr_count), 32'(exp_count));
            if ((r.e & PCW) != 0 && (r.e & ILL) == 0 && (r.e & BERR) == 0)
                exp_count = exp_count + 4'd1;
            cyc++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"}, 32'(obs), 32'h0);
        check({tag, "_cnt"}, 32'(instr_count), 32'h0);
    endtask

    initial begin
        reset = 1'b1; fetch_ack = 1'b0; mem_ack = 1'b0; zero = 1'b0;
        opcode = '0; funct = '0;
        @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        gen_instr(4'd0, 3'b001, 0, 0, 2);   // ALU SUB, immediate acks
        gen_instr(4'd0, 3'b110, 0, 0, 2);   // upper funct bit ignored: AND
        gen_instr(4'd1, 3'b000, 0, 3, 2);   // LW, ack on 4th MEM cycle
        gen_instr(4'd3, 3'b000, 0, 0, 1);   // BEQ taken
        gen_instr(4'd3, 3'b000, 0, 0, 0);   // BEQ not taken
        gen_instr(4'd5, 3'b000, 0, 0, 2);   // illegal
        gen_instr(4'd2, 3'b000, 0, 6, 2);   // SW times out
        gen_instr(4'd2, 3'b000, 0, 3, 2);   // SW ack in the timeout cycle
        gen_instr(4'd0, 3'b011, 5, 0, 2);   // fetch times out once then acks
        gen_instr(4'd1, 3'b000, 1, 5, 2);   // LW times out
        run_recs(1000);

        // reset in the middle of MEM
        gen_instr(4'd1, 3'b000, 0, 3, 2);
        run_recs(5);
        reset = 1'b1;
        #1 check_reset_outputs("midmem");
        q.delete();
        exp_count = '0;
        @(negedge clk);
        #1 check_reset_outputs("midmem_hold");
        @(negedge clk);
        reset = 1'b0;
        gen_instr(4'd0, 3'b000, 0, 0, 2);
        run_recs(1000);

        // randomized instruction stream, long enough to wrap the counter
        for (int k = 0; k < 80; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
            gen_instr(op, 3'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 0,
                      $urandom_range(0, 5), 2);
            run_recs(1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
